// File: rtl/risc_ctrl_seq_pkg.sv
// Shared definitions for the RISC control sequencer: opcodes, phase encoding
// and the ALU-class helper.
package risc_pkg;

    localparam int OP_W = 3;
    localparam int ST_W = 3;

    localparam logic [OP_W-1:0] OP_HLT  = 3'd0;
    localparam logic [OP_W-1:0] OP_SKZ  = 3'd1;
    localparam logic [OP_W-1:0] OP_ADD  = 3'd2;
    localparam logic [OP_W-1:0] OP_ANDD = 3'd3;
    localparam logic [OP_W-1:0] OP_XORR = 3'd4;
    localparam logic [OP_W-1:0] OP_LDA  = 3'd5;
    localparam logic [OP_W-1:0] OP_STO  = 3'd6;
    localparam logic [OP_W-1:0] OP_JMP  = 3'd7;

    typedef enum logic [ST_W-1:0] {
        S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
        S4 = 3'd4, S5 = 3'd5, S6 = 3'd6, S7 = 3'd7
    } phase_e;

    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_ANDD, OP_XORR, OP_LDA: is_alu_op = 1'b1;
            default:                          is_alu_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/risc_ctrl_seq_if.sv
// Control bundle between the sequencer and the rest of the core.
// The master side supplies run enable, opcode and zero flag; the slave returns strobes.
interface risc_ctrl_seq_if;
    import risc_pkg::*;

    logic            ena;
    logic [OP_W-1:0] opcode;
    logic            zero;
    logic            inc_pc;
    logic            load_pc;
    logic            rd;
    logic            wr;
    logic            load_ir;
    logic            datactl_ena;
    logic            load_acc;
    logic            halt;
    logic [ST_W-1:0] phase;

    modport master (
        output ena, opcode, zero,
        input  inc_pc, load_pc, rd, wr, load_ir, datactl_ena, load_acc, halt, phase
    );

    modport slave (
        input  ena, opcode, zero,
        output inc_pc, load_pc, rd, wr, load_ir, datactl_ena, load_acc, halt, phase
    );
endinterface

// File: rtl/risc_ctrl_seq_decode.sv
// Strobe decoder: maps registered sequencer state to the core control strobes.
// Only ena reaches the strobes combinationally, and only as a freeze gate.
module risc_ctrl_decode
    import risc_pkg::*;
(
    input  phase_e          phase,
    input  logic [OP_W-1:0] op,
    input  logic            zero,
    input  logic            halt_q,
    input  logic            ena,
    output logic            inc_pc,
    output logic            load_pc,
    output logic            rd,
    output logic            wr,
    output logic            load_ir,
    output logic            datactl_ena,
    output logic            load_acc,
    output logic            halt
);

    logic alu_s;
    logic sto_s;
    logic jmp_s;
    logic skip_s;

    // Instruction-class flags from the latched opcode and zero flag
    always_comb begin
        alu_s  = is_alu_op(op);
        sto_s  = (op == OP_STO);
        jmp_s  = (op == OP_JMP);
        skip_s = (op == OP_SKZ) && zero;
    end

    // Per-phase strobe decode, silenced while frozen or halted
    always_comb begin
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        rd          = 1'b0;
        wr          = 1'b0;
        load_ir     = 1'b0;
        datactl_ena = 1'b0;
        load_acc    = 1'b0;
        halt        = halt_q | ((phase == S3) && (op == OP_HLT));
        if (ena && !halt_q) begin
            case (phase)
                S0, S1: begin
                    rd      = 1'b1;
                    load_ir = 1'b1;
                    inc_pc  = 1'b1;
                end
                S4: begin
                    rd          = alu_s;
                    load_pc     = jmp_s;
                    datactl_ena = sto_s;
                end
                S5: begin
                    rd          = alu_s;
                    load_acc    = alu_s;
                    load_pc     = jmp_s;
                    inc_pc      = jmp_s | skip_s;
                    wr          = sto_s;
                    datactl_ena = sto_s;
                end
                S6: begin
                    rd          = alu_s;
                    datactl_ena = sto_s;
                end
                S7: begin
                    inc_pc = skip_s;
                end
                default: begin
                    inc_pc = 1'b0;
                end
            endcase
        end else begin
            inc_pc = 1'b0;
        end
    end

endmodule

// File: rtl/risc_ctrl_seq.sv
// Eight-phase instruction sequencer: holds phase, latched opcode/zero and halt
// state, and feeds them to the strobe decoder.
module risc_ctrl_seq
    import risc_pkg::*;
(
    input  logic           clk1,
    input  logic           rst,
    risc_ctrl_seq_if.slave bus
);

    phase_e          phase_r;
    phase_e          phase_nx_s;
    logic [OP_W-1:0] op_r;
    logic [OP_W-1:0] op_nx_s;
    logic            zero_r;
    logic            zero_nx_s;
    logic            halt_r;
    logic            halt_nx_s;

    // Next-state: advance when running; HLT in S3 parks the phase; latch on S2 exit
    always_comb begin
        phase_nx_s = phase_r;
        op_nx_s    = op_r;
        zero_nx_s  = zero_r;
        halt_nx_s  = halt_r;
        if (bus.ena && !halt_r) begin
            if ((phase_r == S3) && (op_r == OP_HLT)) begin
                halt_nx_s = 1'b1;
            end else begin
                phase_nx_s = phase_e'(phase_r + 3'd1);
                if (phase_r == S2) begin
                    op_nx_s   = bus.opcode;
                    zero_nx_s = bus.zero;
                end else begin
                    op_nx_s   = op_r;
                    zero_nx_s = zero_r;
                end
            end
        end else begin
            phase_nx_s = phase_r;
        end
    end

    // State register with synchronous reset taking priority over everything
    always_ff @(posedge clk1) begin
        if (rst) begin
            phase_r <= S0;
            op_r    <= 3'd0;
            zero_r  <= 1'b0;
            halt_r  <= 1'b0;
        end else begin
            phase_r <= phase_nx_s;
            op_r    <= op_nx_s;
            zero_r  <= zero_nx_s;
            halt_r  <= halt_nx_s;
        end
    end

    assign bus.phase = phase_r;

    risc_ctrl_decode u_decode (
        .phase       (phase_r),
        .op          (op_r),
        .zero        (zero_r),
        .halt_q      (halt_r),
        .ena         (bus.ena),
        .inc_pc      (bus.inc_pc),
        .load_pc     (bus.load_pc),
        .rd          (bus.rd),
        .wr          (bus.wr),
        .load_ir     (bus.load_ir),
        .datactl_ena (bus.datactl_ena),
        .load_acc    (bus.load_acc),
        .halt        (bus.halt)
    );

endmodule
